// File: rtl/pll_pkg.sv
// pll_pkg
// Shared definitions for the PLL digital loop filter:
//   lf_state_t : loop-filter FSM states
//   ERR_W      : width of the per-window signed phase error
//   sat_add    : add a -1/0/+1 step to the error, clamped to +/-127
package pll_pkg;

  typedef enum logic [1:0] {
    LF_IDLE    = 2'd0,
    LF_ACQUIRE = 2'd1,
    LF_LOCKED  = 2'd2
  } lf_state_t;

  localparam int ERR_W = 8;

  // Symmetric clamp: -128 is never produced so |err| is always representable.
  function automatic logic signed [ERR_W-1:0] sat_add(
    input logic signed [ERR_W-1:0] a,
    input logic signed [1:0]       b
  );
    logic signed [ERR_W:0] s;
    s = {a[ERR_W-1], a} + {{(ERR_W-1){b[1]}}, b};
    if (s > 9'sd127) begin
      s = 9'sd127;
    end else if (s < -9'sd127) begin
      s = -9'sd127;
    end
    return s[ERR_W-1:0];
  endfunction

endpackage

// File: rtl/sync2.sv
// sync2
// Two-flop synchronizer for a single asynchronous level.
//   clock : destination clock
//   reset : asynchronous active-low reset, output clears to 0
//   d     : asynchronous input
//   q     : synchronized output, two clock edges after d
module sync2 (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta_reg <= 1'b0;
      q        <= 1'b0;
    end else begin
      meta_reg <= d;
      q        <= meta_reg;
    end
  end

endmodule

// File: rtl/pfd_loop_filter.sv
// pfd_loop_filter
// Integrates PFD UP/DN pulse width over each reference period into a signed
// phase error, applies a PI update and drives a saturated DCO control word.
//   clock      : sampling clock, rising edge
//   reset      : asynchronous active-low reset
//   up_in      : PFD UP, asynchronous
//   dn_in      : PFD DN, asynchronous
//   ref_tick   : one-cycle pulse at the end of each reference period
//   ctrl_out   : tuning word, holds between updates
//   ctrl_valid : one-cycle pulse when ctrl_out updates (tick + 2 cycles)
//   locked     : FSM is in the LOCKED state
//   sat        : last update clamped ctrl_out
module pfd_loop_filter
  import pll_pkg::*;
#(
  parameter int CTRL_W    = 10,
  parameter int ACC_W     = 18,
  parameter int KP_SHIFT  = 2,
  parameter int KI_SHIFT  = 6,
  parameter int CTRL_INIT = 512,
  parameter int LOCK_WIN  = 2,
  parameter int LOCK_CNT  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              up_in,
  input  logic              dn_in,
  input  logic              ref_tick,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              ctrl_valid,
  output logic              locked,
  output logic              sat
);

  localparam int CNT_W = $clog2(LOCK_CNT + 1);
  localparam logic signed [ACC_W-1:0] INTEG_INIT  = ACC_W'(CTRL_INIT << KI_SHIFT);
  localparam logic signed [ACC_W:0]   INTEG_MAX_X = (ACC_W+1)'((2 ** (ACC_W - 1)) - 1);
  localparam logic signed [ACC_W:0]   INTEG_MIN_X = (ACC_W+1)'(-(2 ** (ACC_W - 1)));
  localparam logic signed [ACC_W:0]   CTRL_MAX_X  = (ACC_W+1)'((2 ** CTRL_W) - 1);
  localparam logic [CTRL_W-1:0]       CTRL_RST    = CTRL_W'(CTRL_INIT);
  localparam logic signed [ERR_W-1:0] WIN_P       = ERR_W'(LOCK_WIN);
  localparam logic signed [ERR_W-1:0] WIN_N       = ERR_W'(-LOCK_WIN);
  localparam logic [CNT_W-1:0]        CNT_LIM     = CNT_W'(LOCK_CNT);

  // ---------------------------------------------------------------- sync
  logic [1:0] pfd_raw;
  logic [1:0] pfd_s;
  logic       up_s;
  logic       dn_s;

  assign pfd_raw = {dn_in, up_in};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      sync2 u_sync (
        .clock (clock),
        .reset (reset),
        .d     (pfd_raw[gi]),
        .q     (pfd_s[gi])
      );
    end
  endgenerate

  assign up_s = pfd_s[0];
  assign dn_s = pfd_s[1];

  // ---------------------------------------------------- window accumulator
  logic signed [1:0]       step;
  logic signed [ERR_W-1:0] err_acc_reg;
  logic signed [ERR_W-1:0] err_sum;

  // Both high cancels to 0, covering the PFD reset overlap.
  assign step    = {1'b0, up_s} - {1'b0, dn_s};
  assign err_sum = sat_add(err_acc_reg, step);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_acc_reg <= '0;
    end else if (ref_tick) begin
      err_acc_reg <= '0;
    end else begin
      err_acc_reg <= err_sum;
    end
  end

  // ------------------------------------------------- stage 1: integrator
  lf_state_t state_reg, state_next;

  logic                    update_req;
  logic                    upd1_reg;
  logic signed [ERR_W-1:0] err_reg;
  logic signed [ACC_W-1:0] integ_reg;
  logic signed [ACC_W:0]   integ_sum;
  logic signed [ACC_W-1:0] integ_next;

  // The first tick after reset only closes a partial window.
  assign update_req = ref_tick && (state_reg != LF_IDLE);

  always_comb begin
    integ_sum = {integ_reg[ACC_W-1], integ_reg}
              + {{(ACC_W + 1 - ERR_W){err_sum[ERR_W-1]}}, err_sum};
    if (integ_sum > INTEG_MAX_X) begin
      integ_next = INTEG_MAX_X[ACC_W-1:0];
    end else if (integ_sum < INTEG_MIN_X) begin
      integ_next = INTEG_MIN_X[ACC_W-1:0];
    end else begin
      integ_next = integ_sum[ACC_W-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      upd1_reg  <= 1'b0;
      err_reg   <= '0;
      integ_reg <= INTEG_INIT;
    end else begin
      upd1_reg <= update_req;
      if (update_req) begin
        err_reg   <= err_sum;
        integ_reg <= integ_next;
      end
    end
  end

  // --------------------------------------------- stage 2: PI and clamp
  logic signed [ACC_W:0] integ_x;
  logic signed [ACC_W:0] err_x;
  logic signed [ACC_W:0] pi_sum;
  logic [CTRL_W-1:0]     ctrl_next;
  logic                  sat_next;
  logic [CTRL_W-1:0]     ctrl_reg;
  logic                  sat_reg;
  logic                  valid_reg;

  always_comb begin
    integ_x = {integ_reg[ACC_W-1], integ_reg};
    err_x   = {{(ACC_W + 1 - ERR_W){err_reg[ERR_W-1]}}, err_reg};
    pi_sum  = (integ_x >>> KI_SHIFT) + (err_x <<< KP_SHIFT);
    if (pi_sum[ACC_W]) begin
      ctrl_next = '0;
      sat_next  = 1'b1;
    end else if (pi_sum > CTRL_MAX_X) begin
      ctrl_next = '1;
      sat_next  = 1'b1;
    end else begin
      ctrl_next = pi_sum[CTRL_W-1:0];
      sat_next  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ctrl_reg  <= CTRL_RST;
      sat_reg   <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= upd1_reg;
      if (upd1_reg) begin
        ctrl_reg <= ctrl_next;
        sat_reg  <= sat_next;
      end
    end
  end

  // ------------------------------------------------------- lock tracking
  logic             in_win;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  assign in_win = (err_reg <= WIN_P) && (err_reg >= WIN_N);

  always_comb begin
    cnt_next = cnt_reg;
    if (upd1_reg) begin
      if (!in_win) begin
        cnt_next = '0;
      end else if (cnt_reg != CNT_LIM) begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LF_IDLE: begin
        if (ref_tick) state_next = LF_ACQUIRE;
      end
      LF_ACQUIRE: begin
        if (upd1_reg && (cnt_next == CNT_LIM)) state_next = LF_LOCKED;
      end
      LF_LOCKED: begin
        if (upd1_reg && !in_win) state_next = LF_ACQUIRE;
      end
      default: state_next = LF_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= LF_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign ctrl_out   = ctrl_reg;
  assign sat        = sat_reg;
  assign ctrl_valid = valid_reg;
  assign locked     = (state_reg == LF_LOCKED);

endmodule

// File: tb/tb_pfd_loop_filter.sv
module tb_pfd_loop_filter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       up_in = 1'b0;
  logic       dn_in = 1'b0;
  logic       ref_tick = 1'b0;
  logic [9:0] ctrl_out;
  logic       ctrl_valid;
  logic       locked;
  logic       sat;

  int n_vec = 0;
  int n_err = 0;

  pfd_loop_filter dut (
    .clock      (clock),
    .reset      (reset),
    .up_in      (up_in),
    .dn_in      (dn_in),
    .ref_tick   (ref_tick),
    .ctrl_out   (ctrl_out),
    .ctrl_valid (ctrl_valid),
    .locked     (locked),
    .sat        (sat)
  );

  always #5 clock = ~clock;

  typedef struct {
    string name;
    bit    rst;
    int    up_n;
    int    dn_n;
    int    both_n;
    int    exp_ctrl;
    bit    exp_sat;
    bit    exp_locked;
  } vec_t;

  vec_t vecs[5];

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reset, then the discarded first tick which must not produce ctrl_valid.
  task automatic do_reset();
    up_in = 1'b0;
    dn_in = 1'b0;
    ref_tick = 1'b0;
    reset = 1'b0;
    cyc(2);
    chk("rst_ctrl", ctrl_out, 512);
    chk("rst_valid", ctrl_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_sat", sat, 0);
    reset = 1'b1;
    cyc(1);
    ref_tick = 1'b1;
    cyc(1);
    ref_tick = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("discard_valid", ctrl_valid, 0);
      cyc(1);
    end
    chk("discard_ctrl", ctrl_out, 512);
  endtask

  task automatic window(input int up_n, input int dn_n, input int both_n);
    up_in = 1'b1;
    cyc(up_n);
    up_in = 1'b0;
    dn_in = 1'b1;
    cyc(dn_n);
    up_in = 1'b1;
    cyc(both_n);
    up_in = 1'b0;
    dn_in = 1'b0;
    cyc(4);
  endtask

  task automatic tick_check(input string name, input int exp_ctrl,
                            input int exp_sat, input int exp_locked);
    ref_tick = 1'b1;
    cyc(1);
    ref_tick = 1'b0;
    chk({name, "_valid_t1"}, ctrl_valid, 0);
    cyc(1);
    chk({name, "_valid_t2"}, ctrl_valid, 1);
    chk({name, "_ctrl"}, ctrl_out, exp_ctrl);
    chk({name, "_sat"}, sat, exp_sat);
    chk({name, "_locked"}, locked, exp_locked);
    $display("txn %s: ctrl_out=%0d sat=%0d locked=%0d", name, ctrl_out, sat, locked);
    cyc(1);
    chk({name, "_valid_t3"}, ctrl_valid, 0);
    chk({name, "_hold"}, ctrl_out, exp_ctrl);
  endtask

  initial begin
    // integ starts at 512<<6 = 32768; ctrl = (integ >>> 6) + 4*err
    vecs[0] = '{"up10",  1'b1, 10, 0,  0, 552, 1'b0, 1'b0};
    vecs[1] = '{"dn10",  1'b1, 0, 10,  0, 471, 1'b0, 1'b0};
    vecs[2] = '{"both20", 1'b1, 0, 0, 20, 512, 1'b0, 1'b0};
    vecs[3] = '{"up3",   1'b0, 3, 0,   0, 524, 1'b0, 1'b0};  // integ 32771
    vecs[4] = '{"dn2",   1'b0, 0, 2,   0, 504, 1'b0, 1'b0};  // integ 32769

    cyc(1);
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].rst) do_reset();
      window(vecs[v].up_n, vecs[v].dn_n, vecs[v].both_n);
      tick_check(vecs[v].name, vecs[v].exp_ctrl, int'(vecs[v].exp_sat),
                 int'(vecs[v].exp_locked));
    end

    // Lock after 16 in-window updates, lose it on |err| = 5.
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      window(1, 0, 0);
      tick_check($sformatf("lock%0d", k), 516, 0, (k == 16) ? 1 : 0);
    end
    window(5, 0, 0);
    tick_check("unlock", 532, 0, 0);  // integ 32789 -> 512 + 20

    // UP held: err clamps to 127 per window; integ += 127 each update.
    do_reset();
    up_in = 1'b1;
    cyc(300);
    tick_check("sat1", 1021, 0, 0);   // 32895 >>> 6 = 513, +508
    cyc(300);
    tick_check("sat2", 1023, 0, 0);   // 33022 >>> 6 = 515, +508, exact fit
    cyc(300);
    tick_check("sat3", 1023, 1, 0);   // 33149 >>> 6 = 517, +508 = 1025 clamped
    cyc(300);
    tick_check("sat4", 1023, 1, 0);

    // Reset mid-pipeline: outputs return at once, pending update dropped.
    cyc(50);
    ref_tick = 1'b1;
    cyc(1);
    ref_tick = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    chk("midrst_ctrl", ctrl_out, 512);
    chk("midrst_sat", sat, 0);
    chk("midrst_locked", locked, 0);
    chk("midrst_valid", ctrl_valid, 0);
    cyc(1);
    chk("midrst_valid_t2", ctrl_valid, 0);
    up_in = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("postrst_valid", ctrl_valid, 0);
      chk("postrst_ctrl", ctrl_out, 512);
    end
    $display("txn midrst: ctrl_out=%0d sat=%0d locked=%0d", ctrl_out, sat, locked);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
